uart_rx_frontend: RTL

Parametrised multi-channel UART receive front-end, the successor to the single-line input synchronizer. Each channel synchronises its asynchronous RX pin, majority-filters it, and recovers bit timing from line edges. It emits a mid-bit sample strobe with the sampled bit. It sits between the RX pins and the per-channel UART deserialisers.

---
 rtl/definitions_pkg.sv | 19 +
 rtl/uart_rx_channel.sv | 163 ++++++++++++++++
 rtl/uart_rx_frontend.sv | 72 +++++++
 3 files changed

// File: rtl/definitions_pkg.sv
// Shared definitions for the UART receive path: default clock/line rates, channel FSM
// states and bit-timing helpers.
package definitions_pkg;

   localparam int unsigned CLOCK_RATE         = 50_000_000;
   localparam int unsigned BAUD_RATE          = 1_000_000;
   localparam int unsigned BREAK_BITS_DEFAULT = 12;

   typedef enum logic [0:0] {
      RX_IDLE,
      RX_ACTIVE
   } rx_state_e;

   function automatic int unsigned bit_period(input int unsigned clock,
                                              input int unsigned baud);
      return clock / baud;
   endfunction

endpackage

// File: rtl/uart_rx_channel.sv
// One UART RX line: synchroniser, majority filter, edge detect and bit-timing recovery.
// UART_BREAK_DETECT_EN adds a break detector (rx_break) on top of the sampled bits.
module uart_rx_channel
   import definitions_pkg::*;
#(
   parameter int unsigned BIT_PERIOD  = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 3,
   parameter int unsigned IDLE_BITS   = 10
`ifdef UART_BREAK_DETECT_EN
   ,
   parameter int unsigned BREAK_BITS  = BREAK_BITS_DEFAULT
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_in,
   output logic rx_filt,
   output logic rx_edge,
   output logic rx_strobe,
   output logic rx_bit,
   output logic rx_active
`ifdef UART_BREAK_DETECT_EN
   ,
   output logic rx_break
`endif
);

   localparam int unsigned HalfPeriod = BIT_PERIOD / 2;
   localparam int unsigned PhaseW     = $clog2(BIT_PERIOD);
   localparam int unsigned IdleW      = $clog2(IDLE_BITS + 1);
   localparam int unsigned CntW       = $clog2(FILTER_LEN + 1);

   localparam logic [PhaseW-1:0] PhaseHalf = PhaseW'(HalfPeriod);
   localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(BIT_PERIOD - 1);
   localparam logic [IdleW-1:0]  IdleLast  = IdleW'(IDLE_BITS - 1);
   localparam logic [CntW-1:0]   MajThresh = CntW'(FILTER_LEN / 2);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FILTER_LEN-1:0]  filt_sr_q, filt_sr_d;
   logic                   rx_filt_q, rx_filt_d;
   logic                   rx_edge_q, rx_edge_d;
   logic                   rx_bit_q, rx_bit_d;
   rx_state_e              state_q, state_d;
   logic [PhaseW-1:0]      phase_q, phase_d;
   logic [IdleW-1:0]       idle_q, idle_d;
   logic [CntW-1:0]        ones;
   logic                   majority;
   logic                   strobe;

   always_comb begin
      sync_d[0] = rx_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      filt_sr_d[0] = sync_q[SYNC_STAGES-1];
      for (int i = 1; i < FILTER_LEN; i++) filt_sr_d[i] = filt_sr_q[i-1];
      ones = '0;
      for (int i = 0; i < FILTER_LEN; i++) ones = ones + CntW'(filt_sr_q[i]);
      majority  = (ones > MajThresh);
      rx_filt_d = majority;
      rx_edge_d = (majority != rx_filt_q);
   end

   // An edge re-centres the bit clock, so it always takes precedence over a strobe.
   assign strobe = (state_q == RX_ACTIVE) && (phase_q == PhaseHalf) && !rx_edge_q;

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      idle_d   = idle_q;
      rx_bit_d = rx_bit_q;
      if (strobe) rx_bit_d = rx_filt_q;
      unique case (state_q)
         RX_IDLE: begin
            phase_d = '0;
            if (rx_edge_q && !rx_filt_q) begin
               state_d = RX_ACTIVE;
               phase_d = PhaseW'(1);
               idle_d  = '0;
            end
         end
         RX_ACTIVE: begin
            phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhaseW'(1);
            if (rx_edge_q) begin
               phase_d = PhaseW'(1);
               idle_d  = '0;
            end else if (strobe) begin
               if (!rx_filt_q) begin
                  idle_d = '0;
               end else if (idle_q == IdleLast) begin
                  state_d = RX_IDLE;
                  phase_d = '0;
                  idle_d  = '0;
               end else begin
                  idle_d = idle_q + IdleW'(1);
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '1;
         filt_sr_q <= '1;
         rx_filt_q <= 1'b1;
         rx_edge_q <= 1'b0;
         rx_bit_q  <= 1'b1;
         state_q   <= RX_IDLE;
         phase_q   <= '0;
         idle_q    <= '0;
      end else begin
         sync_q    <= sync_d;
         filt_sr_q <= filt_sr_d;
         rx_filt_q <= rx_filt_d;
         rx_edge_q <= rx_edge_d;
         rx_bit_q  <= rx_bit_d;
         state_q   <= state_d;
         phase_q   <= phase_d;
         idle_q    <= idle_d;
      end
   end

   assign rx_filt   = rx_filt_q;
   assign rx_edge   = rx_edge_q;
   assign rx_strobe = strobe;
   // Present the freshly sampled bit alongside its strobe.
   assign rx_bit    = strobe ? rx_filt_q : rx_bit_q;
   assign rx_active = (state_q == RX_ACTIVE);

`ifdef UART_BREAK_DETECT_EN
   localparam int unsigned BrkW = $clog2(BREAK_BITS + 1);
   localparam logic [BrkW-1:0] BrkMax  = BrkW'(BREAK_BITS);
   localparam logic [BrkW-1:0] BrkLast = BrkW'(BREAK_BITS - 1);

   logic [BrkW-1:0] brk_cnt_q, brk_cnt_d;
   logic            break_q, break_d;

   always_comb begin
      brk_cnt_d = brk_cnt_q;
      break_d   = break_q;
      if (strobe) begin
         if (rx_filt_q) brk_cnt_d = '0;
         else if (brk_cnt_q != BrkMax) brk_cnt_d = brk_cnt_q + BrkW'(1);
      end
      if (strobe && !rx_filt_q && (brk_cnt_q == BrkLast)) break_d = 1'b1;
      else if (rx_edge_q && rx_filt_q) break_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brk_cnt_q <= '0;
         break_q   <= 1'b0;
      end else begin
         brk_cnt_q <= brk_cnt_d;
         break_q   <= break_d;
      end
   end

   assign rx_break = break_q;
`endif

endmodule

// File: rtl/uart_rx_frontend.sv
// Multi-channel UART receive front-end: one independent uart_rx_channel per RX pin.
// Define UART_BREAK_DETECT_EN to add the rx_break outputs and BREAK_BITS parameter.
module uart_rx_frontend
   import definitions_pkg::*;
#(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned CLOCK_RATE  = definitions_pkg::CLOCK_RATE,
   parameter int unsigned BAUD_RATE   = definitions_pkg::BAUD_RATE,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 3,
   parameter int unsigned IDLE_BITS   = 10
`ifdef UART_BREAK_DETECT_EN
   ,
   parameter int unsigned BREAK_BITS  = BREAK_BITS_DEFAULT
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] rx_in,
   output logic [CHANNELS-1:0] rx_filt,
   output logic [CHANNELS-1:0] rx_edge,
   output logic [CHANNELS-1:0] rx_strobe,
   output logic [CHANNELS-1:0] rx_bit,
   output logic [CHANNELS-1:0] rx_active
`ifdef UART_BREAK_DETECT_EN
   ,
   output logic [CHANNELS-1:0] rx_break
`endif
);

   localparam int unsigned BitPeriod = bit_period(CLOCK_RATE, BAUD_RATE);

   if (CLOCK_RATE % BAUD_RATE != 0) begin : g_chk_div
      $fatal(1, "CLOCK_RATE must be an integer multiple of BAUD_RATE");
   end
   if (BitPeriod < 8) begin : g_chk_period
      $fatal(1, "bit period must be at least 8 clock cycles");
   end
   if (FILTER_LEN % 2 == 0) begin : g_chk_filter
      $fatal(1, "FILTER_LEN must be odd");
   end
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $fatal(1, "SYNC_STAGES must be at least 2");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      uart_rx_channel #(
         .BIT_PERIOD  (BitPeriod),
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .IDLE_BITS   (IDLE_BITS)
`ifdef UART_BREAK_DETECT_EN
         ,
         .BREAK_BITS  (BREAK_BITS)
`endif
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .rx_in     (rx_in[i]),
         .rx_filt   (rx_filt[i]),
         .rx_edge   (rx_edge[i]),
         .rx_strobe (rx_strobe[i]),
         .rx_bit    (rx_bit[i]),
         .rx_active (rx_active[i])
`ifdef UART_BREAK_DETECT_EN
         ,
         .rx_break  (rx_break[i])
`endif
      );
   end

endmodule
